convolution_2d: RTL and testbench



---
 rtl/snn_interfaces_pkg.sv | 20 ++
 rtl/kernel_bram_if.sv | 14 +
 rtl/kernel_bram.sv | 35 +++
 rtl/convolution_2d.sv | 208 ++++++++++++++++++++
 tb/tb_convolution_2d.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_interfaces_pkg.sv
// Shared SNN datapath types: spike event record and convolution scanner states.
package snn_interfaces_pkg;

    localparam int SNN_IN_CHANNELS   = 2;
    localparam int SNN_COORD_BITS    = 8;
    localparam int SNN_TIMESTEP_BITS = 8;

    typedef struct packed {
        logic [SNN_TIMESTEP_BITS-1:0] timestep;
        logic [SNN_COORD_BITS-1:0]    x;
        logic [SNN_COORD_BITS-1:0]    y;
        logic [SNN_IN_CHANNELS-1:0]   spikes;
    } output_vector_t;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } conv_state_t;

endpackage

// File: rtl/kernel_bram_if.sv
// Single-port kernel weight memory bus between the convolution core and its BRAM.
interface kernel_bram_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 12
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              we;
    logic              en;

    modport bram_module (input addr, data_in, we, en, output data_out);
    modport conv_module (output addr, data_in, we, en, input data_out);
endinterface

// File: rtl/kernel_bram.sv
// Kernel weight store: one word per (channel, ky, kx), OUT_CHANNELS signed weights per word.
module kernel_bram
    import snn_interfaces_pkg::*;
#(
    parameter int KERNEL_WEIGHT_BITS = 6,
    parameter int KERNEL_SIZE        = 3,
    parameter int IN_CHANNELS        = 2,
    parameter int OUT_CHANNELS       = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    kernel_bram_if.bram_module   bus
);

    localparam int DEPTH  = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int DATA_W = OUT_CHANNELS * KERNEL_WEIGHT_BITS;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Array kept out of the reset path so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (bus.en && bus.we) begin
            r_mem[bus.addr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.data_out <= '0;
        end else if (bus.en && !bus.we) begin
            bus.data_out <= r_mem[bus.addr];
        end
    end

endmodule

// File: rtl/convolution_2d.sv
// Event-driven 2-D convolution scatter core; define CONV_ZERO_SKIP_EN to suppress
// updates whose kernel word is all zero.
module convolution_2d
    import snn_interfaces_pkg::*;
#(
    parameter int IN_CHANNELS        = SNN_IN_CHANNELS,
    parameter int OUT_CHANNELS       = 2,
    parameter int KERNEL_SIZE        = 3,
    parameter int KERNEL_WEIGHT_BITS = 6,
    parameter int IMG_WIDTH          = 32,
    parameter int IMG_HEIGHT         = 32,
    parameter int COORD_BITS         = SNN_COORD_BITS,
    parameter int TIMESTEP_BITS      = SNN_TIMESTEP_BITS,
    localparam int DEPTH             = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    localparam int ADDR_W            = $clog2(DEPTH),
    localparam int DATA_W            = OUT_CHANNELS * KERNEL_WEIGHT_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  output_vector_t           event_in,
    input  logic                     event_valid,
    output logic                     event_ready,
    input  logic                     cfg_en,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [DATA_W-1:0]        cfg_wdata,
    output logic [DATA_W-1:0]        cfg_rdata,
    output logic                     upd_valid,
    output logic [COORD_BITS-1:0]    upd_x,
    output logic [COORD_BITS-1:0]    upd_y,
    output logic [TIMESTEP_BITS-1:0] upd_timestep,
    output logic [DATA_W-1:0]        upd_weights
);

    localparam int HALF = KERNEL_SIZE / 2;
    localparam int KW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int CW   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int SW   = COORD_BITS + 2;
    localparam logic [KW-1:0] K_LAST = KW'(KERNEL_SIZE - 1);

    conv_state_t              r_state;
    logic [TIMESTEP_BITS-1:0] r_ts;
    logic [COORD_BITS-1:0]    r_x;
    logic [COORD_BITS-1:0]    r_y;
    logic [IN_CHANNELS-1:0]   r_spikes;
    logic [CW-1:0]            r_ch;
    logic [KW-1:0]            r_ky;
    logic [KW-1:0]            r_kx;
    logic                     r_tap_valid;
    logic [COORD_BITS-1:0]    r_upd_x;
    logic [COORD_BITS-1:0]    r_upd_y;
    logic [TIMESTEP_BITS-1:0] r_upd_ts;
    logic                     r_cfg_pend;
    logic [DATA_W-1:0]        r_cfg_hold;

    logic                     w_accept;
    logic [CW-1:0]            w_first_ch;
    logic                     w_found_first;
    logic [CW-1:0]            w_next_ch;
    logic                     w_has_next;
    logic [ADDR_W-1:0]        w_scan_addr;
    logic [SW-1:0]            w_ox;
    logic [SW-1:0]            w_oy;
    logic                     w_inbound;
    logic                     w_tap_emit;
    logic [DATA_W-1:0]        w_bram_rdata;

    kernel_bram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bram_bus ();

    kernel_bram #(
        .KERNEL_WEIGHT_BITS (KERNEL_WEIGHT_BITS),
        .KERNEL_SIZE        (KERNEL_SIZE),
        .IN_CHANNELS        (IN_CHANNELS),
        .OUT_CHANNELS       (OUT_CHANNELS)
    ) u_kernel_bram (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bram_bus.bram_module)
    );

    // Config port owns the memory only while idle; the scanner reads it in SCAN.
    always_comb begin
        bram_bus.data_in = cfg_wdata;
        if (r_state == ST_SCAN) begin
            bram_bus.en   = 1'b1;
            bram_bus.we   = 1'b0;
            bram_bus.addr = w_scan_addr;
        end else begin
            bram_bus.en   = cfg_en;
            bram_bus.we   = cfg_we;
            bram_bus.addr = cfg_addr;
        end
    end

    assign w_bram_rdata = bram_bus.data_out;
    assign event_ready  = (r_state == ST_IDLE);
    assign w_accept     = event_valid && (r_state == ST_IDLE) && !cfg_en;

    always_comb begin
        w_first_ch    = '0;
        w_found_first = 1'b0;
        w_next_ch     = '0;
        w_has_next    = 1'b0;
        for (int unsigned c = 0; c < IN_CHANNELS; c++) begin
            if (!w_found_first && event_in.spikes[c]) begin
                w_found_first = 1'b1;
                w_first_ch    = CW'(c);
            end
            if (!w_has_next && (c > 32'(r_ch)) && r_spikes[c]) begin
                w_has_next = 1'b1;
                w_next_ch  = CW'(c);
            end
        end
    end

    assign w_scan_addr = ADDR_W'((32'(r_ch) * KERNEL_SIZE + 32'(r_ky)) * KERNEL_SIZE + 32'(r_kx));

    // Two guard bits keep x + kx - K/2 signed so negative targets are detectable.
    assign w_ox      = SW'(r_x) + SW'(r_kx) - SW'(HALF);
    assign w_oy      = SW'(r_y) + SW'(r_ky) - SW'(HALF);
    assign w_inbound = !w_ox[SW-1] && (w_ox < SW'(IMG_WIDTH)) &&
                       !w_oy[SW-1] && (w_oy < SW'(IMG_HEIGHT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ts        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_spikes    <= '0;
            r_ch        <= '0;
            r_ky        <= '0;
            r_kx        <= '0;
            r_tap_valid <= 1'b0;
            r_upd_x     <= '0;
            r_upd_y     <= '0;
            r_upd_ts    <= '0;
        end else begin
            r_tap_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ts     <= event_in.timestep;
                        r_x      <= event_in.x;
                        r_y      <= event_in.y;
                        r_spikes <= event_in.spikes;
                        r_ch     <= w_first_ch;
                        r_ky     <= '0;
                        r_kx     <= '0;
                        if (|event_in.spikes) begin
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    r_tap_valid <= w_inbound;
                    r_upd_x     <= w_ox[COORD_BITS-1:0];
                    r_upd_y     <= w_oy[COORD_BITS-1:0];
                    r_upd_ts    <= r_ts;
                    if (r_kx == K_LAST) begin
                        r_kx <= '0;
                        if (r_ky == K_LAST) begin
                            r_ky <= '0;
                            if (w_has_next) begin
                                r_ch <= w_next_ch;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_ky <= r_ky + 1'b1;
                        end
                    end else begin
                        r_kx <= r_kx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read data is live on the BRAM register the cycle after a strobe, then held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg_pend <= 1'b0;
            r_cfg_hold <= '0;
        end else begin
            r_cfg_pend <= (r_state == ST_IDLE) && cfg_en && !cfg_we;
            if (r_cfg_pend) begin
                r_cfg_hold <= w_bram_rdata;
            end
        end
    end

    assign cfg_rdata = r_cfg_pend ? w_bram_rdata : r_cfg_hold;

`ifdef CONV_ZERO_SKIP_EN
    assign w_tap_emit = r_tap_valid && (|w_bram_rdata);
`else
    assign w_tap_emit = r_tap_valid;
`endif

    assign upd_valid    = w_tap_emit;
    assign upd_x        = r_upd_x;
    assign upd_y        = r_upd_y;
    assign upd_timestep = r_upd_ts;
    assign upd_weights  = w_tap_emit ? w_bram_rdata : '0;

endmodule

// File: tb/tb_convolution_2d.sv
// Directed self-checking bench for convolution_2d (3x3 kernel, 2 in / 2 out channels, 32x32 map).
module tb_convolution_2d;
    import snn_interfaces_pkg::*;

    localparam int AW = 5;
    localparam int DW = 12;

    logic           clk = 1'b0;
    logic           rst_n;
    output_vector_t event_in;
    logic           event_valid;
    logic           event_ready;
    logic           cfg_en;
    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [DW-1:0]  cfg_wdata;
    logic [DW-1:0]  cfg_rdata;
    logic           upd_valid;
    logic [7:0]     upd_x;
    logic [7:0]     upd_y;
    logic [7:0]     upd_timestep;
    logic [DW-1:0]  upd_weights;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    convolution_2d #(
        .IN_CHANNELS        (2),
        .OUT_CHANNELS       (2),
        .KERNEL_SIZE        (3),
        .KERNEL_WEIGHT_BITS (6),
        .IMG_WIDTH          (32),
        .IMG_HEIGHT         (32),
        .COORD_BITS         (8),
        .TIMESTEP_BITS      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .event_in     (event_in),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .cfg_en       (cfg_en),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata),
        .upd_valid    (upd_valid),
        .upd_x        (upd_x),
        .upd_y        (upd_y),
        .upd_timestep (upd_timestep),
        .upd_weights  (upd_weights)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_en    = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_wdata = DW'(d);
        tick();
        cfg_en = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read_strobe(input int a);
        cfg_en   = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = AW'(a);
        tick();
        cfg_en = 1'b0;
    endtask

    task automatic set_event(input logic [7:0] t, input int x, input int y, input logic [1:0] sp);
        event_in.timestep = t;
        event_in.x        = 8'(x);
        event_in.y        = 8'(y);
        event_in.spikes   = sp;
    endtask

    task automatic send_event(input logic [7:0] t, input int x, input int y, input logic [1:0] sp);
        set_event(t, x, y, sp);
        event_valid = 1'b1;
        tick();
        event_valid = 1'b0;
    endtask

    task automatic load_ramp();
        for (int a = 0; a < 18; a++) cfg_write(a, 16 * a + 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_tests++;
        if (event_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", event_ready);
        end
        n_tests++;
        if ({upd_valid, upd_x, upd_y, upd_timestep, upd_weights} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_upd: got v=%b x=%h y=%h t=%h w=%h expected all 0",
                     upd_valid, upd_x, upd_y, upd_timestep, upd_weights);
        end
        n_tests++;
        if (cfg_rdata !== 12'h000) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 000", cfg_rdata);
        end
    endtask

    task automatic test_cfg_rw();
        cfg_write(0, 12'h03F);
        cfg_read_strobe(0);
        n_tests++;
        if (cfg_rdata !== 12'h03F) begin
            n_fail++; $display("FAIL cfg_readback: got %h expected 03F", cfg_rdata);
        end
        tick();
        n_tests++;
        if (cfg_rdata !== 12'h03F) begin
            n_fail++; $display("FAIL cfg_readback_hold: got %h expected 03F", cfg_rdata);
        end
    endtask

    task automatic test_full_event();
        logic [36:0] exp_v;
        logic [36:0] got_v;
        int ky, kx;
        send_event(8'h2A, 5, 3, 2'b11);
        n_tests++;
        if (event_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_ready_c1: got %b expected 0", event_ready);
        end
        for (int i = 0; i < 18; i++) begin
            ky = (i % 9) / 3;
            kx = i % 3;
            tick();
            exp_v = {1'b1, 8'(5 + kx - 1), 8'(3 + ky - 1), 8'h2A, 12'(16 * i + 1)};
            got_v = {upd_valid, upd_x, upd_y, upd_timestep, upd_weights};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL full_tap%0d: got %h expected %h", i, got_v, exp_v);
            end
            n_tests++;
            if (event_ready !== 1'(i == 17)) begin
                n_fail++; $display("FAIL full_ready_tap%0d: got %b expected %b", i, event_ready, (i == 17));
            end
        end
        tick();
        n_tests++;
        if (upd_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_after: got upd_valid %b expected 0", upd_valid);
        end
    endtask

    task automatic test_border();
        int bx, base, nv, kx, ky, ox, oy;
        bit inb;
        logic [1:0] sp;
        for (int s = 0; s < 2; s++) begin
            bx   = (s == 0) ? 0 : 31;
            sp   = (s == 0) ? 2'b01 : 2'b10;
            base = (s == 0) ? 0 : 9;
            nv   = 0;
            send_event(8'(s + 1), bx, bx, sp);
            for (int i = 0; i < 9; i++) begin
                kx  = i % 3;
                ky  = i / 3;
                ox  = bx + kx - 1;
                oy  = bx + ky - 1;
                inb = (ox >= 0) && (ox < 32) && (oy >= 0) && (oy < 32);
                tick();
                if (upd_valid === 1'b1) nv++;
                n_tests++;
                if (inb) begin
                    if ({upd_valid, upd_x, upd_y, upd_weights} !==
                        {1'b1, 8'(ox), 8'(oy), 12'(16 * (base + i) + 1)}) begin
                        n_fail++;
                        $display("FAIL border%0d_tap%0d: got v=%b (%0d,%0d) w=%h expected v=1 (%0d,%0d) w=%h",
                                 s, i, upd_valid, upd_x, upd_y, upd_weights, ox, oy, 16 * (base + i) + 1);
                    end
                end else if (upd_valid !== 1'b0) begin
                    n_fail++; $display("FAIL border%0d_oob%0d: got upd_valid %b expected 0", s, i, upd_valid);
                end
                n_tests++;
                if (event_ready !== 1'(i == 8)) begin
                    n_fail++; $display("FAIL border%0d_ready%0d: got %b expected %b", s, i, event_ready, (i == 8));
                end
            end
            n_tests++;
            if (nv != 4) begin
                n_fail++; $display("FAIL border%0d_count: got %0d updates expected 4", s, nv);
            end
        end
        tick();
    endtask

    task automatic test_zero_spikes();
        send_event(8'h05, 12, 12, 2'b00);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({event_ready, upd_valid} !== 2'b10) begin
                n_fail++; $display("FAIL zero_spikes_c%0d: got ready=%b valid=%b expected ready=1 valid=0",
                                   i, event_ready, upd_valid);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        set_event(8'h01, 10, 10, 2'b01);
        event_valid = 1'b1;
        tick();
        set_event(8'h02, 20, 20, 2'b10);
        for (int i = 0; i < 8; i++) tick();
        n_tests++;
        if (event_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready_c9: got %b expected 0", event_ready);
        end
        tick();
        n_tests++;
        if ({event_ready, upd_valid, upd_x, upd_y, upd_timestep, upd_weights} !==
            {1'b1, 1'b1, 8'd11, 8'd11, 8'h01, 12'h081}) begin
            n_fail++; $display("FAIL b2b_last_a: got r=%b v=%b (%0d,%0d) t=%h w=%h expected r=1 v=1 (11,11) t=01 w=081",
                               event_ready, upd_valid, upd_x, upd_y, upd_timestep, upd_weights);
        end
        tick();
        event_valid = 1'b0;
        n_tests++;
        if ({event_ready, upd_valid} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_gap: got ready=%b valid=%b expected 00", event_ready, upd_valid);
        end
        tick();
        n_tests++;
        if ({upd_valid, upd_x, upd_y, upd_timestep, upd_weights} !== {1'b1, 8'd19, 8'd19, 8'h02, 12'h091}) begin
            n_fail++; $display("FAIL b2b_first_b: got v=%b (%0d,%0d) t=%h w=%h expected v=1 (19,19) t=02 w=091",
                               upd_valid, upd_x, upd_y, upd_timestep, upd_weights);
        end
        for (int i = 0; i < 9; i++) tick();
    endtask

    task automatic test_cfg_during_scan();
        cfg_read_strobe(0);
        n_tests++;
        if (cfg_rdata !== 12'h001) begin
            n_fail++; $display("FAIL scan_cfg_pre: got %h expected 001", cfg_rdata);
        end
        send_event(8'h07, 10, 10, 2'b01);
        cfg_en    = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = AW'(2);
        cfg_wdata = 12'hABC;
        tick();
        tick();
        cfg_we   = 1'b0;
        cfg_addr = AW'(5);
        tick();
        cfg_en = 1'b0;
        n_tests++;
        if (cfg_rdata !== 12'h001) begin
            n_fail++; $display("FAIL scan_cfg_rdata: got %h expected 001", cfg_rdata);
        end
        for (int i = 0; i < 7; i++) tick();
        cfg_read_strobe(2);
        n_tests++;
        if (cfg_rdata !== 12'h021) begin
            n_fail++; $display("FAIL scan_cfg_mem: got %h expected 021", cfg_rdata);
        end
    endtask

    task automatic test_cfg_priority();
        set_event(8'h03, 10, 10, 2'b01);
        event_valid = 1'b1;
        cfg_en      = 1'b1;
        cfg_we      = 1'b0;
        cfg_addr    = AW'(3);
        tick();
        cfg_en = 1'b0;
        n_tests++;
        if ({event_ready, cfg_rdata} !== {1'b1, 12'h031}) begin
            n_fail++; $display("FAIL prio_cfg: got ready=%b rdata=%h expected ready=1 rdata=031", event_ready, cfg_rdata);
        end
        tick();
        event_valid = 1'b0;
        n_tests++;
        if (event_ready !== 1'b0) begin
            n_fail++; $display("FAIL prio_accept: got ready=%b expected 0", event_ready);
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset_mid_scan();
        logic seen;
        send_event(8'h04, 10, 10, 2'b11);
        tick();
        tick();
        tick();
        n_tests++;
        if (upd_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_scan_pre: got upd_valid %b expected 1", upd_valid);
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({upd_valid, event_ready, cfg_rdata} !== {1'b0, 1'b1, 12'h000}) begin
            n_fail++; $display("FAIL rst_scan_abort: got valid=%b ready=%b rdata=%h expected valid=0 ready=1 rdata=000",
                               upd_valid, event_ready, cfg_rdata);
        end
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (upd_valid !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL rst_scan_quiet: got stray upd_valid=1 expected none");
        end
        cfg_read_strobe(1);
        n_tests++;
        if (cfg_rdata !== 12'h011) begin
            n_fail++; $display("FAIL rst_scan_mem: got %h expected 011", cfg_rdata);
        end
    endtask

    task automatic test_zero_tap();
        cfg_write(4, 0);
        send_event(8'h06, 10, 10, 2'b01);
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
`ifdef CONV_ZERO_SKIP_EN
        if (upd_valid !== 1'b0) begin
            n_fail++; $display("FAIL zero_tap_skip: got upd_valid %b expected 0", upd_valid);
        end
`else
        if ({upd_valid, upd_x, upd_y, upd_weights} !== {1'b1, 8'd10, 8'd10, 12'h000}) begin
            n_fail++; $display("FAIL zero_tap_emit: got v=%b (%0d,%0d) w=%h expected v=1 (10,10) w=000",
                               upd_valid, upd_x, upd_y, upd_weights);
        end
`endif
        tick();
        n_tests++;
        if ({upd_valid, upd_x, upd_y, upd_weights} !== {1'b1, 8'd11, 8'd10, 12'h051}) begin
            n_fail++; $display("FAIL zero_tap_next: got v=%b (%0d,%0d) w=%h expected v=1 (11,10) w=051",
                               upd_valid, upd_x, upd_y, upd_weights);
        end
        for (int i = 0; i < 5; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        event_in    = '0;
        event_valid = 1'b0;
        cfg_en      = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_wdata   = '0;
        test_reset();
        test_cfg_rw();
        load_ramp();
        test_full_event();
        test_border();
        test_zero_spikes();
        test_back_to_back();
        test_cfg_during_scan();
        test_cfg_priority();
        test_reset_mid_scan();
        test_zero_tap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
